// File: rtl/ps2_key_tracker_if.sv
// rtl/ps2_key_tracker_if.sv - byte pop handshake between PS/2 receiver FIFO and key tracker
//   ps2_data       : byte at receiver FIFO head (receiver -> tracker)
//   ps2_ready      : receiver FIFO non-empty (receiver -> tracker)
//   ps2_nextdata_n : active-low pop strobe (tracker -> receiver)
interface ps2_key_tracker_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_nextdata_n;

    modport master (output ps2_data, output ps2_ready, input ps2_nextdata_n);
    modport slave  (input ps2_data, input ps2_ready, output ps2_nextdata_n);
endinterface

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 decoder with held-key tracking, press counter and press history
//   clk, rst      : clock, synchronous active-low reset
//   ps2 (slave)   : ps2_data/ps2_ready in, ps2_nextdata_n out (pop handshake)
//   key_code/key_ext/key_held : most recent new press and whether it is still down
//   press_cnt     : wrapping count of distinct presses
//   press_pulse/release_pulse : one-cycle strobes
//   hist_idx -> hist_data     : registered history read, 0 = newest, {ext, code}
//   hist_count    : valid history entries, saturating at HIST_DEPTH
//   seg0..seg3    : active-low hex digits, only when PS2_KEY_TRACKER_SEG_EN is defined
module ps2_key_tracker #(
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    ps2_key_tracker_if.slave                ps2,
    output logic [7:0]                      key_code,
    output logic                            key_ext,
    output logic                            key_held,
    output logic [CNT_W-1:0]                press_cnt,
    output logic                            press_pulse,
    output logic                            release_pulse,
    input  logic [$clog2(HIST_DEPTH)-1:0]   hist_idx,
    output logic [8:0]                      hist_data,
    output logic [$clog2(HIST_DEPTH):0]     hist_count
`ifdef PS2_KEY_TRACKER_SEG_EN
    ,
    output logic [6:0]                      seg0,
    output logic [6:0]                      seg1,
    output logic [6:0]                      seg2,
    output logic [6:0]                      seg3
`endif
);
    localparam int IW = $clog2(HIST_DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t           state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_held_q, key_held_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic [IW-1:0]    hist_wptr_q, hist_wptr_d;
    logic [CW-1:0]    hist_count_q, hist_count_d;
    logic [8:0]       hist_data_q, hist_data_d;
    logic [8:0]       hist_mem [HIST_DEPTH];

    logic             accept;
    logic             ev_make, ev_break, ev_ext, is_current, push;
    logic [IW-1:0]    rd_ptr;

    // The pop strobe doubles as the busy flag: no accept while it is low.
    assign accept = ps2.ps2_ready && nextdata_n_q;

    always_comb begin
        state_d         = state_q;
        ev_make         = 1'b0;
        ev_break        = 1'b0;
        ev_ext          = 1'b0;
        key_code_d      = key_code_q;
        key_ext_d       = key_ext_q;
        key_held_d      = key_held_q;
        press_cnt_d     = press_cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        push            = 1'b0;
        hist_wptr_d     = hist_wptr_q;
        hist_count_d    = hist_count_q;
        nextdata_n_d    = !accept;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2.ps2_data == 8'hE0)      state_d = S_EXT;
                    else if (ps2.ps2_data == 8'hF0) state_d = S_BRK;
                    else                            ev_make = 1'b1;
                end
                S_EXT: begin
                    if (ps2.ps2_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_break = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end

        is_current = key_held_q && (ev_ext == key_ext_q) && (ps2.ps2_data == key_code_q);

        // A make matching the held key is a typematic repeat and changes nothing.
        if (ev_make && !is_current) begin
            key_code_d    = ps2.ps2_data;
            key_ext_d     = ev_ext;
            key_held_d    = 1'b1;
            press_cnt_d   = press_cnt_q + CNT_W'(1);
            press_pulse_d = 1'b1;
            push          = 1'b1;
            hist_wptr_d   = hist_wptr_q + IW'(1);
            if (hist_count_q != CW'(HIST_DEPTH))
                hist_count_d = hist_count_q + CW'(1);
        end

        if (ev_break && is_current) begin
            key_held_d      = 1'b0;
            release_pulse_d = 1'b1;
        end

        // Read uses pre-push pointer/contents; newest entry sits just below the write pointer.
        rd_ptr = hist_wptr_q - IW'(1) - hist_idx;
        if ({1'b0, hist_idx} >= hist_count_q) hist_data_d = 9'd0;
        else                                  hist_data_d = hist_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst && push) hist_mem[hist_wptr_q] <= {ev_ext, ps2.ps2_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            nextdata_n_q    <= 1'b1;
            key_code_q      <= 8'd0;
            key_ext_q       <= 1'b0;
            key_held_q      <= 1'b0;
            press_cnt_q     <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            hist_wptr_q     <= '0;
            hist_count_q    <= '0;
            hist_data_q     <= 9'd0;
        end else begin
            state_q         <= state_d;
            nextdata_n_q    <= nextdata_n_d;
            key_code_q      <= key_code_d;
            key_ext_q       <= key_ext_d;
            key_held_q      <= key_held_d;
            press_cnt_q     <= press_cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            hist_wptr_q     <= hist_wptr_d;
            hist_count_q    <= hist_count_d;
            hist_data_q     <= hist_data_d;
        end
    end

    assign ps2.ps2_nextdata_n = nextdata_n_q;
    assign key_code           = key_code_q;
    assign key_ext            = key_ext_q;
    assign key_held           = key_held_q;
    assign press_cnt          = press_cnt_q;
    assign press_pulse        = press_pulse_q;
    assign release_pulse      = release_pulse_q;
    assign hist_data          = hist_data_q;
    assign hist_count         = hist_count_q;

`ifdef PS2_KEY_TRACKER_SEG_EN
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] on;
        case (n)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    logic [6:0] seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d;
    logic [7:0] cnt8;

    // Driven from the next-state values so digits change together with key_*/press_cnt.
    always_comb begin
        cnt8   = 8'(press_cnt_d);
        seg0_d = key_held_d ? hex7(key_code_d[3:0]) : 7'h7F;
        seg1_d = key_held_d ? hex7(key_code_d[7:4]) : 7'h7F;
        seg2_d = hex7(cnt8[3:0]);
        seg3_d = hex7(cnt8[7:4]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg0_q <= 7'h7F;
            seg1_q <= 7'h7F;
            seg2_q <= 7'h7F;
            seg3_q <= 7'h7F;
        end else begin
            seg0_q <= seg0_d;
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
            seg3_q <= seg3_d;
        end
    end

    assign seg0 = seg0_q;
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign seg3 = seg3_q;
`endif
endmodule
